icsc_csc_444to422: RTL and testbench
====================================

Name: icsc_csc_444to422

Overview:
- Downstream neighbour of the 3x3 colour-space matrix stage.
- Consumes its YCbCr 4:4:4 stream: Y unsigned, Cb/Cr signed, with vs/hs/de timing.
- Emits 4:2:2: Y every pixel, plus one chroma sample per pixel alternating Cb (even pixel) and Cr (odd pixel).
- Chroma is either pair-averaged with rounding or co-sited decimated (even-pixel chroma kept).
- Fixed pipeline latency, so sync signals stay aligned with data.

Parameters:
- DATA_WIDTH, 8, bit width of Y, Cb, Cr and output chroma.
- AVG_EN_DEF, 1, reset/default selection when i_avg_en is tied to this value; informational only, no logic.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- i_avg_en  input  1  1 = average chroma of pixel pair, 0 = co-sited (take even pixel chroma); sampled at line start only
- i_vs  input  1  vertical sync
- i_hs  input  1  horizontal sync
- i_de  input  1  data enable
- i_y  input  DATA_WIDTH  luma, unsigned
- i_cb  input  DATA_WIDTH  Cb, signed two's complement
- i_cr  input  DATA_WIDTH  Cr, signed two's complement
- o_vs  output  1  i_vs delayed 2 cycles
- o_hs  output  1  i_hs delayed 2 cycles
- o_de  output  1  i_de delayed 2 cycles
- o_y  output  DATA_WIDTH  luma delayed 2 cycles
- o_c  output  DATA_WIDTH  signed chroma: Cb on even output pixels, Cr on odd

Behaviour:
- Reset: all outputs 0; pipeline registers 0; phase = 0; latched mode = 1.
- Latency: exactly 2 clk for vs/hs/de/y/c, independent of mode. Input at edge N appears on outputs after edge N+2.
- Pipeline:
  - Stage 1 registers the input set.
  - Stage 2 registers the outputs.
  - Pairing is done between the stage-1 pixel and the current input pixel.
- Line definition:
  - A line is a contiguous run of i_de=1.
  - i_de 0->1 starts a line: phase forced to 0 and i_avg_en latched into the mode register.
  - Any de=0 cycle ends the line; mid-line gaps are not supported and are treated as line end + new line.
- Phase: toggles on every de=1 stage-1 pixel. Phase 0 = even pixel, 1 = odd pixel.
- Even stage-1 pixel (phase 0):
  - Partner = current input if i_de=1, else the even pixel itself (odd-length line, replicate).
  - Average mode: o_c <= (cb_e + cb_p + 1) >>> 1, computed at DATA_WIDTH+1 bits signed, arithmetic shift, round half toward +inf. Result always fits in DATA_WIDTH; no clip needed.
  - Co-sited mode: o_c <= cb_e.
  - Cr result for the pair is computed the same way and held in a pending register.
- Odd stage-1 pixel (phase 1): o_c <= pending Cr. Pending Cr is never reused across pairs.
- Odd-length line: the last even pixel outputs its own Cb. No Cr is emitted for it; pending Cr is discarded at line end.
- o_y: stage-1 Y, unmodified.
- When stage-1 de=0: o_y and o_c are driven 0. o_vs/o_hs still follow input timing.
- Mode change mid-line is ignored until the next line start.
- Async reset mid-line: everything clears immediately. The next de rising edge starts a fresh line at phase 0.
- Back-to-back lines with a single de=0 gap are supported at full throughput (1 pixel/clk).

Test Plan:
- Average mode, line of 4 pixels: Cb = {10, 20, -4, -5}, Cr = {100, 101, -128, -127}, Y = {1, 2, 3, 4}, contiguous de -> o_c = {15, 101, -4, -127}, o_y = {1, 2, 3, 4}, o_de high exactly 2 cycles after i_de.
- Co-sited mode, same line -> o_c = {10, 100, -4, -128}.
- Odd-length line of 3 pixels, average mode: Cb = {0, 2, 7}, Cr = {4, 6, 9} -> o_c = {1, 5, 7}; o_de low in the following cycle; next line starts with Cb at phase 0.
- Extremes: Cb pair {127, 127} -> 127; {-128, -128} -> -128; {-1, 0} -> 0 (round up); {-3, -2} -> -2.
- i_avg_en toggled mid-line -> current line keeps the old mode; the next line uses the new mode.
- rstn pulsed low after pixel 1 of a line -> all outputs 0 immediately. After release, a new 2-pixel line (Cb 8/4, Cr 2/2) gives o_c = {6, 2}; o_vs/o_hs keep 2-cycle alignment throughout.

Source files
------------

// File: rtl/icsc_csc_444to422.sv
// YCbCr 4:4:4 -> 4:2:2 chroma resampler. Two-stage pipeline: Y passes straight through,
// and chroma alternates Cb/Cr per pixel, either pair-averaged with rounding or co-sited.
module icsc_csc_444to422 #(
    parameter int DATA_WIDTH = 8,
    parameter bit AVG_EN_DEF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_avg_en,
    input  logic                  i_vs,
    input  logic                  i_hs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_y,
    input  logic [DATA_WIDTH-1:0] i_cb,
    input  logic [DATA_WIDTH-1:0] i_cr,
    output logic                  o_vs,
    output logic                  o_hs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic [DATA_WIDTH-1:0] o_c
);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // Board-level tie-off hint for i_avg_en only; it does not alter the datapath.
    if (AVG_EN_DEF) begin : g_avg_def_on
    end

    logic                  r_s1_vs;
    logic                  r_s1_hs;
    logic                  r_s1_de;
    logic [DATA_WIDTH-1:0] r_s1_y;
    logic [DATA_WIDTH-1:0] r_s1_cb;
    logic [DATA_WIDTH-1:0] r_s1_cr;
    logic [DATA_WIDTH-1:0] r_pend_cr;
    logic                  r_mode;
    phase_t                r_phase;
    phase_t                w_phase_nxt;
    logic                  w_line_start;
    logic [DATA_WIDTH-1:0] w_cb_p;
    logic [DATA_WIDTH-1:0] w_cr_p;
    logic [DATA_WIDTH:0]   w_cb_sum;
    logic [DATA_WIDTH:0]   w_cr_sum;
    logic [DATA_WIDTH-1:0] w_cb_res;
    logic [DATA_WIDTH-1:0] w_cr_res;

    // Stage-1 de holds the previous input de, so a 0->1 here marks a new line.
    assign w_line_start = i_de && !r_s1_de;

    always_comb begin
        w_phase_nxt = PH_EVEN;
        if (i_de && r_s1_de) begin
            w_phase_nxt = (r_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        end
    end

    always_comb begin
        w_cb_p   = i_de ? i_cb : r_s1_cb;
        w_cr_p   = i_de ? i_cr : r_s1_cr;
        // Sign-extended sum plus one; dropping the LSB is the arithmetic shift.
        w_cb_sum = {r_s1_cb[DATA_WIDTH-1], r_s1_cb} + {w_cb_p[DATA_WIDTH-1], w_cb_p}
                 + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_cr_sum = {r_s1_cr[DATA_WIDTH-1], r_s1_cr} + {w_cr_p[DATA_WIDTH-1], w_cr_p}
                 + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_cb_res = r_mode ? w_cb_sum[DATA_WIDTH:1] : r_s1_cb;
        w_cr_res = r_mode ? w_cr_sum[DATA_WIDTH:1] : r_s1_cr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= PH_EVEN;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vs <= 1'b0;
            r_s1_hs <= 1'b0;
            r_s1_de <= 1'b0;
            r_s1_y  <= '0;
            r_s1_cb <= '0;
            r_s1_cr <= '0;
            r_mode  <= 1'b1;
        end else begin
            r_s1_vs <= i_vs;
            r_s1_hs <= i_hs;
            r_s1_de <= i_de;
            r_s1_y  <= i_y;
            r_s1_cb <= i_cb;
            r_s1_cr <= i_cr;
            if (w_line_start) begin
                r_mode <= i_avg_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vs      <= 1'b0;
            o_hs      <= 1'b0;
            o_de      <= 1'b0;
            o_y       <= '0;
            o_c       <= '0;
            r_pend_cr <= '0;
        end else begin
            o_vs <= r_s1_vs;
            o_hs <= r_s1_hs;
            o_de <= r_s1_de;
            if (!r_s1_de) begin
                o_y       <= '0;
                o_c       <= '0;
                r_pend_cr <= '0;
            end else if (r_phase == PH_EVEN) begin
                o_y       <= r_s1_y;
                o_c       <= w_cb_res;
                r_pend_cr <= w_cr_res;
            end else begin
                o_y       <= r_s1_y;
                o_c       <= r_pend_cr;
            end
        end
    end

endmodule

// File: tb/tb_icsc_csc_444to422.sv
// Directed bench for icsc_csc_444to422: per-scenario tasks with hand-computed chroma,
// luma and 2-cycle sync alignment expectations.
module tb_icsc_csc_444to422;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_avg_en;
    logic          i_vs;
    logic          i_hs;
    logic          i_de;
    logic [DW-1:0] i_y;
    logic [DW-1:0] i_cb;
    logic [DW-1:0] i_cr;
    logic          o_vs;
    logic          o_hs;
    logic          o_de;
    logic [DW-1:0] o_y;
    logic [DW-1:0] o_c;

    int n_cmp = 0;
    int n_bad = 0;

    int s_de[16], s_vs[16], s_hs[16], s_avg[16], s_y[16], s_cb[16], s_cr[16];
    logic cap_de[16], cap_vs[16], cap_hs[16];
    int   cap_y[16], cap_c[16];

    icsc_csc_444to422 #(.DATA_WIDTH(DW), .AVG_EN_DEF(1'b1)) dut (
        .clk(clk), .rstn(rstn), .i_avg_en(i_avg_en),
        .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
        .i_y(i_y), .i_cb(i_cb), .i_cr(i_cr),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_y(o_y), .o_c(o_c)
    );

    always #5 clk = ~clk;

    task automatic set_px(input int idx, input int de, input int vs, input int hs,
                          input int avg, input int y, input int cb, input int cr);
        s_de[idx] = de; s_vs[idx] = vs; s_hs[idx] = hs; s_avg[idx] = avg;
        s_y[idx] = y; s_cb[idx] = cb; s_cr[idx] = cr;
    endtask

    // Drives n stimulus entries; output for entry k is captured one edge after entry k+1 is applied.
    task automatic drive_run(input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                i_de = s_de[i][0]; i_vs = s_vs[i][0]; i_hs = s_hs[i][0]; i_avg_en = s_avg[i][0];
                i_y = s_y[i][DW-1:0]; i_cb = s_cb[i][DW-1:0]; i_cr = s_cr[i][DW-1:0];
            end else begin
                i_de = 1'b0; i_vs = 1'b0; i_hs = 1'b0; i_y = '0; i_cb = '0; i_cr = '0;
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                cap_de[i-1] = o_de; cap_vs[i-1] = o_vs; cap_hs[i-1] = o_hs;
                cap_y[i-1] = int'(o_y); cap_c[i-1] = int'($signed(o_c));
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_avg_en = 1'b1; i_vs = 1'b1; i_hs = 1'b1; i_de = 1'b1;
        i_y = 8'd55; i_cb = 8'd66; i_cr = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (o_vs !== 1'b0) begin n_bad++; $display("FAIL reset o_vs: got %0b want 0", o_vs); end
        n_cmp++; if (o_hs !== 1'b0) begin n_bad++; $display("FAIL reset o_hs: got %0b want 0", o_hs); end
        n_cmp++; if (o_de !== 1'b0) begin n_bad++; $display("FAIL reset o_de: got %0b want 0", o_de); end
        n_cmp++; if (o_y !== 8'd0) begin n_bad++; $display("FAIL reset o_y: got %0d want 0", o_y); end
        n_cmp++; if (o_c !== 8'd0) begin n_bad++; $display("FAIL reset o_c: got %0d want 0", o_c); end
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_y = '0; i_cb = '0; i_cr = '0;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_avg();
        int e_y[6] = '{0, 1, 2, 3, 4, 0};
        int e_c[6] = '{0, 15, 101, -4, -127, 0};
        set_px(0, 0, 1, 1, 1, 0, 0, 0);
        set_px(1, 1, 0, 0, 1, 1, 10, 100);
        set_px(2, 1, 0, 0, 1, 2, 20, 101);
        set_px(3, 1, 0, 0, 1, 3, -4, -128);
        set_px(4, 1, 0, 0, 1, 4, -5, -127);
        set_px(5, 0, 0, 1, 1, 0, 0, 0);
        drive_run(6);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL avg o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_vs[i] !== s_vs[i][0]) begin n_bad++; $display("FAIL avg o_vs[%0d]: got %0b want %0b", i, cap_vs[i], s_vs[i][0]); end
            n_cmp++; if (cap_hs[i] !== s_hs[i][0]) begin n_bad++; $display("FAIL avg o_hs[%0d]: got %0b want %0b", i, cap_hs[i], s_hs[i][0]); end
            n_cmp++; if (cap_y[i] !== e_y[i]) begin n_bad++; $display("FAIL avg o_y[%0d]: got %0d want %0d", i, cap_y[i], e_y[i]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL avg o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    task automatic test_cosited();
        int e_c[6] = '{0, 10, 100, -4, -128, 0};
        set_px(0, 0, 0, 1, 0, 0, 0, 0);
        set_px(1, 1, 0, 0, 0, 1, 10, 100);
        set_px(2, 1, 0, 0, 0, 2, 20, 101);
        set_px(3, 1, 0, 0, 0, 3, -4, -128);
        set_px(4, 1, 0, 0, 0, 4, -5, -127);
        set_px(5, 0, 1, 0, 0, 0, 0, 0);
        drive_run(6);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL cosited o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_vs[i] !== s_vs[i][0]) begin n_bad++; $display("FAIL cosited o_vs[%0d]: got %0b want %0b", i, cap_vs[i], s_vs[i][0]); end
            n_cmp++; if (cap_hs[i] !== s_hs[i][0]) begin n_bad++; $display("FAIL cosited o_hs[%0d]: got %0b want %0b", i, cap_hs[i], s_hs[i][0]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL cosited o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    task automatic test_odd_line();
        int e_y[8] = '{0, 1, 2, 3, 0, 4, 5, 0};
        int e_c[8] = '{0, 1, 5, 7, 0, 6, 2, 0};
        set_px(0, 0, 1, 1, 1, 0, 0, 0);
        set_px(1, 1, 0, 0, 1, 1, 0, 4);
        set_px(2, 1, 0, 0, 1, 2, 2, 6);
        set_px(3, 1, 0, 0, 1, 3, 7, 9);
        set_px(4, 0, 0, 1, 1, 0, 0, 0);
        set_px(5, 1, 0, 0, 1, 4, 8, 2);
        set_px(6, 1, 0, 0, 1, 5, 4, 2);
        set_px(7, 0, 0, 0, 1, 0, 0, 0);
        drive_run(8);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL odd o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_hs[i] !== s_hs[i][0]) begin n_bad++; $display("FAIL odd o_hs[%0d]: got %0b want %0b", i, cap_hs[i], s_hs[i][0]); end
            n_cmp++; if (cap_y[i] !== e_y[i]) begin n_bad++; $display("FAIL odd o_y[%0d]: got %0d want %0d", i, cap_y[i], e_y[i]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL odd o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    task automatic test_extremes();
        int cb[8]  = '{127, 127, -128, -128, -1, 0, -3, -2};
        int e_c[10] = '{0, 127, 0, -128, 0, 0, 0, -2, 0, 0};
        set_px(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) set_px(i + 1, 1, 0, 0, 1, 20 + i, cb[i], 0);
        set_px(9, 0, 0, 0, 1, 0, 0, 0);
        drive_run(10);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL extremes o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL extremes o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    task automatic test_mode_switch();
        int cb[4]   = '{10, 20, -4, -5};
        int cr[4]   = '{100, 101, -128, -127};
        int av1[4]  = '{1, 1, 0, 0};
        int av2[4]  = '{0, 1, 1, 1};
        int e_c[11] = '{0, 15, 101, -4, -127, 0, 10, 100, -4, -128, 0};
        set_px(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) set_px(i + 1, 1, 0, 0, av1[i], i + 1, cb[i], cr[i]);
        set_px(5, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) set_px(i + 6, 1, 0, 0, av2[i], i + 1, cb[i], cr[i]);
        set_px(10, 0, 0, 0, 1, 0, 0, 0);
        drive_run(11);
        for (int i = 0; i < 11; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL mode o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL mode o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    task automatic test_reset_midline();
        int e_y[4] = '{0, 5, 6, 0};
        int e_c[4] = '{0, 6, 2, 0};
        i_avg_en = 1'b1; i_vs = 1'b0; i_hs = 1'b0;
        i_de = 1'b1; i_y = 8'd9; i_cb = 8'd50; i_cr = 8'd60;
        @(posedge clk); #1;
        i_y = 8'd10; i_cb = 8'd30; i_cr = 8'd20;
        @(posedge clk); #1;
        n_cmp++; if (o_de !== 1'b1) begin n_bad++; $display("FAIL midrst pre o_de: got %0b want 1", o_de); end
        n_cmp++; if (o_y !== 8'd9) begin n_bad++; $display("FAIL midrst pre o_y: got %0d want 9", o_y); end
        n_cmp++; if (o_c !== 8'd40) begin n_bad++; $display("FAIL midrst pre o_c: got %0d want 40", o_c); end
        i_de = 1'b0; i_y = '0; i_cb = '0; i_cr = '0;
        rstn = 1'b0;
        #1;
        n_cmp++; if (o_de !== 1'b0) begin n_bad++; $display("FAIL midrst o_de: got %0b want 0", o_de); end
        n_cmp++; if (o_y !== 8'd0) begin n_bad++; $display("FAIL midrst o_y: got %0d want 0", o_y); end
        n_cmp++; if (o_c !== 8'd0) begin n_bad++; $display("FAIL midrst o_c: got %0d want 0", o_c); end
        @(posedge clk); #1;
        rstn = 1'b1;
        set_px(0, 0, 1, 1, 1, 0, 0, 0);
        set_px(1, 1, 0, 0, 1, 5, 8, 2);
        set_px(2, 1, 0, 0, 1, 6, 4, 2);
        set_px(3, 0, 0, 1, 1, 0, 0, 0);
        drive_run(4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_de[i] !== s_de[i][0]) begin n_bad++; $display("FAIL midrst o_de[%0d]: got %0b want %0b", i, cap_de[i], s_de[i][0]); end
            n_cmp++; if (cap_vs[i] !== s_vs[i][0]) begin n_bad++; $display("FAIL midrst o_vs[%0d]: got %0b want %0b", i, cap_vs[i], s_vs[i][0]); end
            n_cmp++; if (cap_hs[i] !== s_hs[i][0]) begin n_bad++; $display("FAIL midrst o_hs[%0d]: got %0b want %0b", i, cap_hs[i], s_hs[i][0]); end
            n_cmp++; if (cap_y[i] !== e_y[i]) begin n_bad++; $display("FAIL midrst o_y[%0d]: got %0d want %0d", i, cap_y[i], e_y[i]); end
            n_cmp++; if (cap_c[i] !== e_c[i]) begin n_bad++; $display("FAIL midrst o_c[%0d]: got %0d want %0d", i, cap_c[i], e_c[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_avg();
        test_cosited();
        test_odd_line();
        test_extremes();
        test_mode_switch();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
